// File: rtl/lab1_selftest_if.sv
// Bundle of signals between the lab1 ALU self-test sequencer and its environment.
// The master side is the sequencer: it drives the ALU operands and buttons and
// reports status, while it receives start and the ALU result.
// Optional first-failure capture signals exist only when
// LAB1_SELFTEST_FIRST_FAIL_EN is defined.
interface lab1_selftest_if;
    logic       start;
    logic [3:0] result_in;
    logic       LEFT_pushbutton_out;
    logic       RIGHT_pushbutton_out;
    logic [3:0] A_out;
    logic [3:0] B_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [9:0] err_count;
`ifdef LAB1_SELFTEST_FIRST_FAIL_EN
    logic       fail_valid;
    logic       fail_op;
    logic [3:0] fail_a;
    logic [3:0] fail_b;
    logic [3:0] fail_got;

    modport master (
        input  start, result_in,
        output LEFT_pushbutton_out, RIGHT_pushbutton_out, A_out, B_out,
        output busy, done, pass, err_count,
        output fail_valid, fail_op, fail_a, fail_b, fail_got
    );
    modport slave (
        output start, result_in,
        input  LEFT_pushbutton_out, RIGHT_pushbutton_out, A_out, B_out,
        input  busy, done, pass, err_count,
        input  fail_valid, fail_op, fail_a, fail_b, fail_got
    );
`else
    modport master (
        input  start, result_in,
        output LEFT_pushbutton_out, RIGHT_pushbutton_out, A_out, B_out,
        output busy, done, pass, err_count
    );
    modport slave (
        output start, result_in,
        input  LEFT_pushbutton_out, RIGHT_pushbutton_out, A_out, B_out,
        input  busy, done, pass, err_count
    );
`endif
endinterface

// File: rtl/lab1_selftest.sv
// Exhaustive self-test sequencer for the lab1 4-bit ALU.
// Walks all 256 AND vectors, then all 256 ADD vectors, holding each vector for
// SETTLE_CYCLES+1 cycles and comparing the ALU result on the last edge of the
// hold window. Mismatches are counted in err_count.
// Optional feature: define LAB1_SELFTEST_FIRST_FAIL_EN to capture the first
// mismatching vector of each run on the fail_* outputs.
//
// state | meaning
// IDLE  | after reset, ALU inputs parked at 0, waiting for start
// RUN   | stepping through the 512 vectors
// DONE  | run finished, result held, start relaunches a run
module lab1_selftest #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    lab1_selftest_if.master bus
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [8:0] LAST_VEC    = 9'd511;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] vec_q, vec_d;
    logic [3:0] settle_q, settle_d;
    logic [9:0] err_q, err_d;

    // Vector index layout: bit 8 selects the op (0 = AND), then A, then B,
    // so a plain increment walks B fastest, then A, then the op.
    logic       cur_op;
    logic [3:0] cur_a;
    logic [3:0] cur_b;
    logic [4:0] cur_sum;
    logic [3:0] expected;
    logic       sample_now;
    logic       mismatch;
    logic       launch;

    assign cur_op     = vec_q[8];
    assign cur_a      = vec_q[7:4];
    assign cur_b      = vec_q[3:0];
    assign cur_sum    = {1'b0, cur_a} + {1'b0, cur_b};
    assign expected   = cur_op ? cur_sum[3:0] : (cur_a & cur_b);
    assign sample_now = (state_q == RUN) && (settle_q == 4'd0);
    assign mismatch   = sample_now && (bus.result_in != expected);
    assign launch     = (state_q != RUN) && bus.start;

    // Next-state logic: launch from IDLE/DONE, step vectors on terminal count.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    vec_d    = 9'd0;
                    settle_d = SETTLE_LOAD;
                    err_d    = 10'd0;
                end
            end
            RUN: begin
                if (settle_q == 4'd0) begin
                    if (mismatch) begin
                        err_d = err_q + 10'd1;
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d  = DONE;
                        vec_d    = 9'd0;
                        settle_d = 4'd0;
                    end else begin
                        vec_d    = vec_q + 9'd1;
                        settle_d = SETTLE_LOAD;
                    end
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                vec_d    = 9'd0;
                settle_d = 4'd0;
            end
        endcase
    end

    // State, vector index, settle timer and error counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= 9'd0;
            settle_q <= 4'd0;
            err_q    <= 10'd0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
        end
    end

    // ALU drive and status outputs; ALU inputs are parked at 0 outside RUN.
    always_comb begin
        bus.LEFT_pushbutton_out  = 1'b0;
        bus.RIGHT_pushbutton_out = 1'b0;
        bus.A_out                = 4'd0;
        bus.B_out                = 4'd0;
        if (state_q == RUN) begin
            bus.LEFT_pushbutton_out  = ~cur_op;
            bus.RIGHT_pushbutton_out = cur_op;
            bus.A_out                = cur_a;
            bus.B_out                = cur_b;
        end
        bus.busy      = (state_q == RUN);
        bus.done      = (state_q == DONE);
        bus.pass      = (state_q == DONE) && (err_q == 10'd0);
        bus.err_count = err_q;
    end

`ifdef LAB1_SELFTEST_FIRST_FAIL_EN
    logic       fail_valid_q, fail_valid_d;
    logic       fail_op_q, fail_op_d;
    logic [3:0] fail_a_q, fail_a_d;
    logic [3:0] fail_b_q, fail_b_d;
    logic [3:0] fail_got_q, fail_got_d;

    // First-mismatch capture: cleared at launch, frozen after the first hit.
    always_comb begin
        fail_valid_d = fail_valid_q;
        fail_op_d    = fail_op_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;
        fail_got_d   = fail_got_q;
        if (launch) begin
            fail_valid_d = 1'b0;
            fail_op_d    = 1'b0;
            fail_a_d     = 4'd0;
            fail_b_d     = 4'd0;
            fail_got_d   = 4'd0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_op_d    = cur_op;
            fail_a_d     = cur_a;
            fail_b_d     = cur_b;
            fail_got_d   = bus.result_in;
        end
    end

    // First-mismatch capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_valid_q <= 1'b0;
            fail_op_q    <= 1'b0;
            fail_a_q     <= 4'd0;
            fail_b_q     <= 4'd0;
            fail_got_q   <= 4'd0;
        end else begin
            fail_valid_q <= fail_valid_d;
            fail_op_q    <= fail_op_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
            fail_got_q   <= fail_got_d;
        end
    end

    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_op    = fail_op_q;
    assign bus.fail_a     = fail_a_q;
    assign bus.fail_b     = fail_b_q;
    assign bus.fail_got   = fail_got_q;
`else
    logic unused_launch;
    assign unused_launch = launch;
`endif

endmodule

// File: tb/tb_lab1_selftest.sv
// Self-checking bench for lab1_selftest with an ALU model that can be told to
// misbehave in fixed or random ways; expected error counts come from a
// vector-by-vector walk of the AND/ADD rules.
module tb_lab1_selftest;

    localparam int S       = 2;
    localparam int RUN_LEN = 512 * (S + 1);

    logic clk;
    logic rst;
    lab1_selftest_if bus ();

    lab1_selftest #(.SETTLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_checks  = 0;
    int passed_checks = 0;
    int seq_err       = 0;

    // ALU behaviour: 0 good, 1 forced zero, 2 ADD bit0 stuck at 0, 3 random faults
    int         alu_mode = 0;
    bit         fault_mask [512];
    logic [3:0] fault_xor  [512];

    function automatic logic [3:0] alu_fn(input int mode, input logic left,
                                          input logic right, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [3:0] good;
        int idx;
        idx  = (right ? 256 : 0) + int'(a) * 16 + int'(b);
        good = right ? 4'((int'(a) + int'(b)) % 16) : (left ? (a & b) : 4'd0);
        case (mode)
            1:       return 4'd0;
            2:       return right ? (good & 4'b1110) : good;
            3:       return fault_mask[idx] ? (good ^ fault_xor[idx]) : good;
            default: return good;
        endcase
    endfunction

    always_comb bus.result_in = alu_fn(alu_mode, bus.LEFT_pushbutton_out,
                                       bus.RIGHT_pushbutton_out, bus.A_out, bus.B_out);

    task automatic chk(input string tag, input int got, input int exp);
        total_checks++;
        assert (got === exp) passed_checks++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    endtask

    // Reference: walk every vector in run order and count disagreements.
    task automatic model(input int mode, output int errs, output int f_op,
                         output int f_a, output int f_b, output int f_got);
        int exp_v, got_v;
        errs = 0; f_op = 0; f_a = 0; f_b = 0; f_got = 0;
        for (int op = 0; op < 2; op++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    exp_v = (op == 1) ? (a + b) % 16 : (a & b);
                    got_v = int'(alu_fn(mode, op == 0, op == 1, 4'(a), 4'(b)));
                    if (got_v != exp_v) begin
                        if (errs == 0) begin
                            f_op = op; f_a = a; f_b = b; f_got = got_v;
                        end
                        errs++;
                    end
                end
    endtask

    task automatic new_faults();
        for (int i = 0; i < 512; i++) begin
            fault_mask[i] = ($urandom % 5) == 0;
            fault_xor[i]  = 4'($urandom_range(1, 15));
        end
    endtask

    function automatic logic [9:0] exp_tup(input int idx);
        return {idx < 256, idx >= 256, 4'((idx / 16) % 16), 4'(idx % 16)};
    endfunction

    // Sequence monitor: order of vectors and hold length of each.
    initial begin
        logic [9:0] tup, prev;
        bit active;
        int m_idx, m_hold;
        active = 0; prev = '0; m_idx = 0; m_hold = 0;
        forever begin
            @(posedge clk);
            #1;
            tup = {bus.LEFT_pushbutton_out, bus.RIGHT_pushbutton_out, bus.A_out, bus.B_out};
            if (rst) begin
                active = 0;
            end else if (bus.busy && !active) begin
                active = 1; m_idx = 0; m_hold = 1;
                if (tup !== exp_tup(0)) seq_err++;
            end else if (bus.busy) begin
                if (tup === prev) m_hold++;
                else begin
                    if (m_hold != S + 1) seq_err++;
                    m_idx++;
                    if (tup !== exp_tup(m_idx)) seq_err++;
                    m_hold = 1;
                end
            end else if (active) begin
                active = 0;
                if (m_idx != 511 || m_hold != S + 1) seq_err++;
            end
            prev = tup;
        end
    end

    // Called between edges; start is sampled at the next edge.
    task automatic launch(input string tag);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({tag, "_launch_status"},
            int'({bus.busy, bus.done, bus.pass, bus.LEFT_pushbutton_out,
                  bus.RIGHT_pushbutton_out, bus.A_out, bus.B_out}),
            int'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0}));
        chk({tag, "_launch_err"}, int'(bus.err_count), 0);
    endtask

    task automatic wait_done(input string tag, input int mode, input bit pulse_mid);
        int n, errs, f_op, f_a, f_b, f_got;
        model(mode, errs, f_op, f_a, f_b, f_got);
        n = 0;
        while (n < RUN_LEN + 200 && !bus.done) begin
            @(posedge clk);
            #1;
            n++;
            if (pulse_mid && n == 700) bus.start = 1'b1;
            if (pulse_mid && n == 702) bus.start = 1'b0;
        end
        chk({tag, "_latency"}, n, RUN_LEN);
        chk({tag, "_err"}, int'(bus.err_count), errs);
        chk({tag, "_pass"}, int'({bus.pass, bus.busy}), int'({errs == 0, 1'b0}));
        chk({tag, "_parked"},
            int'({bus.LEFT_pushbutton_out, bus.RIGHT_pushbutton_out, bus.A_out, bus.B_out}), 0);
`ifdef LAB1_SELFTEST_FIRST_FAIL_EN
        chk({tag, "_fail_valid"}, int'(bus.fail_valid), int'(errs != 0));
        if (errs != 0) begin
            chk({tag, "_fail_vec"},
                int'({bus.fail_op, bus.fail_a, bus.fail_b, bus.fail_got}),
                int'({1'(f_op), 4'(f_a), 4'(f_b), 4'(f_got)}));
        end
`endif
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            int'({bus.busy, bus.done, bus.pass, bus.err_count, bus.LEFT_pushbutton_out,
                  bus.RIGHT_pushbutton_out, bus.A_out, bus.B_out}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_hold", int'({bus.busy, bus.done}), 0);

        alu_mode = 0;
        launch("good");
        wait_done("good", 0, 1'b0);

        alu_mode = 1;
        launch("zero");
        wait_done("zero", 1, 1'b0);
        chk("zero_count_415", int'(bus.err_count), 415);

        // start held in DONE relaunches at the very next edge
        launch("restart");
        wait_done("restart", 1, 1'b0);

        alu_mode = 2;
        launch("addbit0");
        wait_done("addbit0", 2, 1'b0);
        chk("addbit0_count_128", int'(bus.err_count), 128);

        for (int r = 0; r < 2; r++) begin
            new_faults();
            alu_mode = 3;
            launch("random");
            wait_done("random", 3, 1'b0);
        end

        alu_mode = 0;
        launch("pulse");
        wait_done("pulse", 0, 1'b1);

        // abort mid-run at vector 100 with a faulty ALU so errors have piled up
        alu_mode = 1;
        launch("abort");
        n = 0;
        while (n < 100 * (S + 1)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_pre_err_nonzero", int'(bus.err_count != 0), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_async_outputs",
            int'({bus.busy, bus.done, bus.pass, bus.err_count, bus.LEFT_pushbutton_out,
                  bus.RIGHT_pushbutton_out, bus.A_out, bus.B_out}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_idle", int'({bus.busy, bus.done, bus.err_count}), 0);
        launch("fresh");
        wait_done("fresh", 1, 1'b0);

        chk("sequence_errors", seq_err, 0);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/lab1_selftest.md
LAB1_SELFTEST -- requirements
Module: lab1_selftest

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: wait cycles per vector after driving the ALU inputs and before sampling its result; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  level, sampled in IDLE or DONE; begins a test run.
REQ-005 result_in  input  4  ALU result; the block treats it as combinational from its own outputs.
REQ-006 LEFT_pushbutton_out  output  1  drives the ALU LEFT_pushbutton input (AND select).
REQ-007 RIGHT_pushbutton_out  output  1  drives the ALU RIGHT_pushbutton input (ADD select).
REQ-008 A_out  output  4  operand A to the ALU.
REQ-009 B_out  output  4  operand B to the ALU.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high from run completion until the next start or reset.
REQ-012 pass  output  1  valid while done is high; 1 = zero mismatches.
REQ-013 err_count  output  10  mismatch count of the current or last run; range 0..512.

Function
REQ-014 The state machine SHALL have exactly three states, IDLE, RUN and DONE, with these transitions: IDLE->RUN on start=1; RUN->DONE after the last vector is sampled; DONE->RUN on start=1; all other cases hold the current state.
REQ-015 The run SHALL apply 512 vectors: op AND (LEFT=1, RIGHT=0) first, then op ADD (LEFT=0, RIGHT=1); within each op, A increments 0..15 in the outer loop and B increments 0..15 in the inner loop.
REQ-016 In IDLE and DONE, both button outputs SHALL be 0 and A_out/B_out SHALL hold 0.
REQ-017 At the edge that leaves IDLE or DONE, vector 0 SHALL be driven, busy SHALL go to 1, done SHALL go to 0, and err_count SHALL clear to 0.
REQ-018 Each vector SHALL be held stable for exactly SETTLE_CYCLES+1 cycles.
REQ-019 result_in SHALL be compared on the last edge of a vector's hold window; the next vector SHALL be driven at that same edge.
REQ-020 The expected value SHALL be A&B for op AND and (A+B) mod 16 for op ADD; the carry is discarded.
REQ-021 Each mismatch SHALL increment err_count by 1; no saturation is required (maximum 512).
REQ-022 done SHALL assert, and busy deassert, at the comparison edge of vector 511, which is 512*(SETTLE_CYCLES+1) edges after the start edge.
REQ-023 pass SHALL equal (err_count==0) and SHALL be valid only while done=1; pass SHALL be 0 otherwise.
REQ-024 start=1 in RUN SHALL be ignored.
REQ-025 start held high in DONE SHALL restart the run immediately.

Reset
REQ-026 rst=1 SHALL asynchronously force the following, including mid-run: IDLE state, all outputs 0, settle counter 0, vector index 0.
REQ-027 After rst deasserts, the block SHALL remain in IDLE until start=1 is sampled.

Configuration
REQ-028 With macro LAB1_SELFTEST_FIRST_FAIL_EN defined, the block SHALL add these outputs, which capture the first mismatch of a run and clear at run start:
- fail_valid (1)
- fail_op (1; 0 = AND)
- fail_a (4)
- fail_b (4)
- fail_got (4)
REQ-029 With LAB1_SELFTEST_FIRST_FAIL_EN undefined, those ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Correct ALU model, SETTLE_CYCLES=2, start pulse -> done=1 exactly 1536 edges after start; pass=1; err_count=0.
REQ-031 ALU model with result forced to 4'b0000 -> err_count=415 (175 AND + 240 ADD); pass=0.
REQ-032 ALU model with result bit0 stuck at 0 for ADD only -> err_count=128; pass=0.
REQ-033 rst asserted at vector 100 mid-run -> all outputs 0 with no clock edge; after release, a start gives a fresh run with err_count counted from 0.
REQ-034 start pulsed during RUN -> no effect on the vector sequence or completion time; start held high in DONE -> err_count clears and vector 0 is driven at the next edge.
REQ-035 LAB1_SELFTEST_FIRST_FAIL_EN defined, forced-zero ALU model -> at done: fail_valid=1, fail_op=0, fail_a=1, fail_b=1, fail_got=0.
